// File: rtl/output_line_fifo.sv
// rtl/output_line_fifo.sv - first-word fall-through output line buffer with stall back-pressure
module output_line_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         stall,
  output logic                         almost_full,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  full, empty, push, pop;

  // Status flags come only from registered count, so out_ready never reaches stall.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_en && !full && !clr;
  assign pop   = !empty && out_ready && !clr;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en && full);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign stall        = full;
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign out_valid    = !empty;
  assign out_data     = empty ? '0 : mem_q[rd_ptr_q];
  assign count        = count_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_output_line_fifo.sv
// tb/tb_output_line_fifo.sv - directed self-checking bench for output_line_fifo
module tb_output_line_fifo;

  logic        clk = 1'b0;
  logic        rst, clr, wr_en, out_ready;
  logic [15:0] wr_data;
  logic        stall, almost_full, out_valid, overflow_err;
  logic [15:0] out_data;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  output_line_fifo #(.DATA_WIDTH(16), .DEPTH(8), .AF_LEVEL(6)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .stall(stall), .almost_full(almost_full), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .count(count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " count"}, 32'(count), 0);
    check({tag, " out_valid"}, 32'(out_valid), 0);
    check({tag, " out_data"}, 32'(out_data), 0);
    check({tag, " stall"}, 32'(stall), 0);
    check({tag, " almost_full"}, 32'(almost_full), 0);
    check({tag, " overflow_err"}, 32'(overflow_err), 0);
  endtask

  task automatic push_n(input int n, input logic [15:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_data = base + 16'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check_reset_state("t1 reset");

    // 1: single push then pop
    wr_en = 1'b1; wr_data = 16'h1234;
    step();
    wr_en = 1'b0;
    check("t1 valid", 32'(out_valid), 1);
    check("t1 data", 32'(out_data), 32'h1234);
    check("t1 count", 32'(count), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1 empty valid", 32'(out_valid), 0);
    check("t1 empty data", 32'(out_data), 0);
    check("t1 empty count", 32'(count), 0);
    out_ready = 1'b1;
    step();
    check("t1 ready on empty", 32'(out_valid), 0);

    // 2: fill to full, watch almost_full and stall, then overflow
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 16'(i);
      step();
      check($sformatf("t2 count %0d", i), 32'(count), 32'(i));
      check($sformatf("t2 af %0d", i), 32'(almost_full), (i >= 6) ? 1 : 0);
      check($sformatf("t2 stall %0d", i), 32'(stall), (i == 8) ? 1 : 0);
    end
    wr_data = 16'h0009;
    step();
    check("t2 ovf count", 32'(count), 8);
    check("t2 ovf err", 32'(overflow_err), 1);
    check("t2 ovf head", 32'(out_data), 1);

    // 3: full with wr_en held; one pop frees a slot, word accepted the next cycle
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t3 after pop count", 32'(count), 7);
    check("t3 after pop stall", 32'(stall), 0);
    check("t3 after pop head", 32'(out_data), 2);
    step();
    wr_en = 1'b0;
    check("t3 accepted count", 32'(count), 8);
    out_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      check($sformatf("t3 drain %0d", k), 32'(out_data), 32'(k));
      step();
    end
    out_ready = 1'b0;
    check("t3 drained count", 32'(count), 0);

    // 4: steady push+pop at count 3 across pointer wrap
    push_n(3, 16'h0100);
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = 16'h0103 + 16'(i); out_ready = 1'b1;
      check($sformatf("t4 head %0d", i), 32'(out_data), 32'h0100 + 32'(i));
      step();
      check($sformatf("t4 count %0d", i), 32'(count), 3);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4 tail %0d", i), 32'(out_data), 32'h0114 + 32'(i));
      step();
    end
    out_ready = 1'b0;
    check("t4 empty", 32'(out_valid), 0);

    // 5: clr discards same-cycle push/pop, overflow_err untouched
    do_reset();
    push_n(5, 16'h0500);
    check("t5 pre count", 32'(count), 5);
    clr = 1'b1; wr_en = 1'b1; wr_data = 16'hAAAA; out_ready = 1'b1;
    step();
    clr = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
    check("t5 count", 32'(count), 0);
    check("t5 valid", 32'(out_valid), 0);
    check("t5 ovf", 32'(overflow_err), 0);
    push_n(8, 16'h0600);
    clr = 1'b1; wr_en = 1'b1;
    step();
    clr = 1'b0; wr_en = 1'b0;
    check("t5 clr full count", 32'(count), 0);
    check("t5 clr full ovf", 32'(overflow_err), 1);

    // 6: rst mid-drain
    do_reset();
    push_n(4, 16'h0700);
    out_ready = 1'b1;
    step();
    check("t6 mid count", 32'(count), 3);
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0;
    check_reset_state("t6 reset");
    wr_en = 1'b1; wr_data = 16'hBEEF;
    step();
    wr_en = 1'b0;
    check("t6 beef valid", 32'(out_valid), 1);
    check("t6 beef data", 32'(out_data), 32'hBEEF);
    out_ready = 1'b1;
    step();
    check("t6 beef popped", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
